// File: rtl/lsu_pkg.sv
// Shared LSU definitions: bus widths, funct3 encodings, FSM states and
// the access-size misalignment rule used when an instruction is accepted.
package lsu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  // Undefined funct3 encodings behave as word accesses.
  function automatic logic lsu_misaligned(logic is_load, logic [2:0] f3, logic [1:0] off);
    logic is_byte;
    logic is_half;
    is_byte = is_load ? (f3 == LSU_LB || f3 == LSU_LBU) : (f3 == LSU_SB);
    is_half = is_load ? (f3 == LSU_LH || f3 == LSU_LHU) : (f3 == LSU_SH);
    if (is_byte) return 1'b0;
    if (is_half) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Single-outstanding request/grant/response data bus between the LSU
// (master) and memory (slave).
interface lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication + byte strobes, and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          off_i,
  input  logic [DATA_W-1:0]   rs2_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   ldata_o
);
  localparam int NB = DATA_W / 8;

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = rdata_i[{off_i, 3'b000} +: 8];
  assign ld_h = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    wdata_o = rs2_i;
    wstrb_o = '1;
    case (funct3_i)
      LSU_SB: begin
        wdata_o = {NB{rs2_i[7:0]}};
        wstrb_o = NB'(1) << off_i;
      end
      LSU_SH: begin
        wdata_o = {(NB/2){rs2_i[15:0]}};
        wstrb_o = NB'(3) << {off_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata_o = rdata_i;
    case (funct3_i)
      LSU_LB:  ldata_o = {{(DATA_W-8){ld_b[7]}}, ld_b};
      LSU_LH:  ldata_o = {{(DATA_W-16){ld_h[15]}}, ld_h};
      LSU_LBU: ldata_o = {{(DATA_W-8){1'b0}}, ld_b};
      LSU_LHU: ldata_o = {{(DATA_W-16){1'b0}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory instruction at a time, runs it over
// the request/grant/response bus and hands the result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sys_valid,
  output logic              o_sys_ready,
  input  logic              i_idu_ctr_ram_rd_en,
  input  logic              i_idu_ctr_ram_wr_en,
  input  logic [2:0]        i_idu_ctr_ram_byt,
  input  logic [ADDR_W-1:0] i_exu_res,
  input  logic [DATA_W-1:0] i_gpr_rs2_data,
  output logic              o_sys_valid,
  input  logic              i_sys_ready,
  output logic [DATA_W-1:0] o_lsu_res,
  output logic              o_lsu_misalign,
  lsu_if.master             mem
);

  lsu_state_e          state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                mis_q, mis_d;

  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W/8-1:0] al_wstrb;
  logic [DATA_W-1:0]   al_ldata;
  logic                acc_mis;
  logic                acc_mem;
  logic                st_req;
  logic                st_wr;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .rs2_i    (rs2_q),
    .rdata_i  (mem.rdata),
    .wdata_o  (al_wdata),
    .wstrb_o  (al_wstrb),
    .ldata_o  (al_ldata)
  );

  assign acc_mem = i_idu_ctr_ram_rd_en | i_idu_ctr_ram_wr_en;
  assign acc_mis = acc_mem &
                   lsu_misaligned(i_idu_ctr_ram_rd_en, i_idu_ctr_ram_byt, i_exu_res[1:0]);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    res_d   = res_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (i_sys_valid) begin
          // A load wins when both enables are set.
          rd_d    = i_idu_ctr_ram_rd_en;
          wr_d    = i_idu_ctr_ram_wr_en & ~i_idu_ctr_ram_rd_en;
          f3_d    = i_idu_ctr_ram_byt;
          addr_d  = i_exu_res;
          rs2_d   = i_gpr_rs2_data;
          res_d   = '0;
          mis_d   = acc_mis;
          state_d = (!acc_mem || acc_mis) ? DONE : REQ;
        end
      end
      REQ: begin
        // Response in the grant cycle is not sampled here.
        if (mem.gnt) state_d = rd_q ? WAIT : DONE;
      end
      WAIT: begin
        if (mem.rvalid) begin
          res_d   = al_ldata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_sys_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign st_req = (state_q == REQ);
  assign st_wr  = st_req & wr_q;

  assign o_sys_ready    = (state_q == IDLE);
  assign o_sys_valid    = (state_q == DONE);
  assign o_lsu_res      = res_q;
  assign o_lsu_misalign = mis_q;

  assign mem.req   = st_req;
  assign mem.we    = st_wr;
  assign mem.addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.wdata = st_wr ? al_wdata : '0;
  assign mem.wstrb = st_wr ? al_wstrb : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected results are queued at issue and popped
// when writeback sees o_sys_valid.
module tb_lsu;

  typedef struct {
    logic [31:0] res;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_valid_i;
  logic        sys_ready_o;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  byt;
  logic [31:0] exu_res;
  logic [31:0] rs2;
  logic        sys_valid_o;
  logic        sys_ready_i;
  logic [31:0] lsu_res;
  logic        lsu_mis;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  lsu_if #(.DATA_W(32), .ADDR_W(32)) mem ();

  lsu dut (
    .i_sys_clk           (clk),
    .i_sys_rst           (rst),
    .i_sys_valid         (sys_valid_i),
    .o_sys_ready         (sys_ready_o),
    .i_idu_ctr_ram_rd_en (rd_en),
    .i_idu_ctr_ram_wr_en (wr_en),
    .i_idu_ctr_ram_byt   (byt),
    .i_exu_res           (exu_res),
    .i_gpr_rs2_data      (rs2),
    .o_sys_valid         (sys_valid_o),
    .i_sys_ready         (sys_ready_i),
    .o_lsu_res           (lsu_res),
    .o_lsu_misalign      (lsu_mis),
    .mem                 (mem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] d, logic [31:0] eres, logic emis);
    exp_t e;
    e.res = eres;
    e.mis = emis;
    sb.push_back(e);
    rd_en = rd; wr_en = wr; byt = f3; exu_res = a; rs2 = d;
    sys_valid_i = 1'b1;
    chkb("ready_idle", sys_ready_o, 1'b1);
    tick();
    sys_valid_i = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    cyc = 1;
  endtask

  task automatic bus(int stall, logic [31:0] eaddr, logic ewe, logic [31:0] ewd,
                     logic [3:0] ews, logic ld, logic [31:0] rdat);
    chkb("req", mem.req, 1'b1);
    chk("addr", mem.addr, eaddr);
    chkb("we", mem.we, ewe);
    if (ewe) begin
      chk("wdata", mem.wdata, ewd);
      chk("wstrb", 32'(mem.wstrb), 32'(ews));
    end
    repeat (stall) begin
      tick();
      cyc++;
      chkb("req_stall", mem.req, 1'b1);
      chk("addr_stall", mem.addr, eaddr);
      chkb("ready_busy", sys_ready_o, 1'b0);
    end
    mem.gnt = 1'b1;
    tick();
    cyc++;
    mem.gnt = 1'b0;
    if (ld) begin
      chkb("req_wait", mem.req, 1'b0);
      mem.rvalid = 1'b1;
      mem.rdata  = rdat;
      tick();
      cyc++;
      mem.rvalid = 1'b0;
      mem.rdata  = '0;
    end
  endtask

  task automatic retire(int lat, int hold);
    exp_t e;
    while (!sys_valid_o && cyc < 30) begin
      tick();
      cyc++;
    end
    chkb("valid", sys_valid_o, 1'b1);
    chk("latency", 32'(cyc), 32'(lat));
    chkb("ready_done", sys_ready_o, 1'b0);
    chkb("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("res", lsu_res, e.res);
      chkb("misalign", lsu_mis, e.mis);
      repeat (hold) begin
        tick();
        chkb("valid_hold", sys_valid_o, 1'b1);
        chkb("ready_hold", sys_ready_o, 1'b0);
        chk("res_hold", lsu_res, e.res);
      end
    end
    sys_ready_i = 1'b1;
    tick();
    sys_ready_i = 1'b0;
    chkb("valid_drop", sys_valid_o, 1'b0);
    chkb("ready_back", sys_ready_o, 1'b1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chkb({tag, "_ready"}, sys_ready_o, 1'b1);
    chkb({tag, "_valid"}, sys_valid_o, 1'b0);
    chkb({tag, "_req"}, mem.req, 1'b0);
    chkb({tag, "_we"}, mem.we, 1'b0);
    chk({tag, "_addr"}, mem.addr, 32'h0);
    chk({tag, "_wdata"}, mem.wdata, 32'h0);
    chk({tag, "_wstrb"}, 32'(mem.wstrb), 32'h0);
    chk({tag, "_res"}, lsu_res, 32'h0);
    chkb({tag, "_mis"}, lsu_mis, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    sys_valid_i = 1'b0; sys_ready_i = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; byt = 3'b000; exu_res = '0; rs2 = '0;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    #2;
    chk_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // LB sign-extend from top byte
    drive(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1'b0);
    bus(0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h80FF_1234);
    retire(3, 0);

    // LHU upper half
    drive(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h0000_BEEF, 1'b0);
    bus(0, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1, 32'hBEEF_0000);
    retire(3, 0);

    // SH upper half
    drive(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1'b0);
    bus(0, 32'h0000_3000, 1'b1, 32'hABCD_ABCD, 4'b1100, 1'b0, 32'h0);
    retire(2, 0);

    // SW with 3-cycle grant stall and 2-cycle writeback stall
    drive(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus(3, 32'h0000_5000, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0);
    retire(5, 2);

    // misaligned LW: no bus request
    drive(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 1'b1);
    chkb("mis_noreq", mem.req, 1'b0);
    retire(1, 0);

    // non-memory op with an odd address is not misaligned
    drive(1'b0, 1'b0, 3'b010, 32'h0000_4003, 32'h0000_1234, 32'h0, 1'b0);
    chkb("nonmem_noreq", mem.req, 1'b0);
    retire(1, 0);

    // SB to byte 1
    drive(1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'h0, 1'b0);
    bus(0, 32'h0000_6000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 1'b0, 32'h0);
    retire(2, 0);

    // LH with both enables set: treated as a load, sign-extended
    drive(1'b1, 1'b1, 3'b001, 32'h0000_7000, 32'hFFFF_FFFF, 32'hFFFF_8001, 1'b0);
    bus(0, 32'h0000_7000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1234_8001);
    retire(3, 0);

    // reset while waiting for a load response, then a late rvalid
    drive(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 1'b0);
    chkb("rw_req", mem.req, 1'b1);
    mem.gnt = 1'b1;
    tick();
    mem.gnt = 1'b0;
    chkb("rw_in_wait", mem.req, 1'b0);
    sb.delete();
    rst = 1'b1;
    #2;
    chk_reset_outputs("rw_async");
    tick();
    rst = 1'b0;
    mem.rvalid = 1'b1;
    mem.rdata  = 32'hCAFE_F00D;
    tick();
    mem.rvalid = 1'b0;
    tick();
    chk_reset_outputs("rw_late");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the l2 core, sitting between the execute stage and writeback. It takes one memory instruction at a time from upstream via a valid/ready handshake and drives a single-outstanding request/grant/response data bus. Load data is aligned and sign- or zero-extended, store strobes and data lanes are generated, and the word-size result is presented to writeback as `o_lsu_res`. Non-memory instructions pass through in one cycle.

## Interface
- `DATA_W`, 32: data width; only 32 is supported.
- `ADDR_W`, 32: address width.

- `i_sys_clk` in 1: clock.
- `i_sys_rst` in 1: reset, asynchronous, active-high.
- `i_sys_valid` in 1: upstream instruction valid.
- `o_sys_ready` out 1: LSU can accept an instruction.
- `i_idu_ctr_ram_rd_en` in 1: instruction is a load.
- `i_idu_ctr_ram_wr_en` in 1: instruction is a store. Rd and wr both high is illegal; rd wins.
- `i_idu_ctr_ram_byt` in 3: funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `i_exu_res` in ADDR_W: effective address.
- `i_gpr_rs2_data` in DATA_W: store data.
- `o_sys_valid` out 1: result valid to writeback.
- `i_sys_ready` in 1: writeback accepts.
- `o_lsu_res` out DATA_W: extended load data; 0 for stores and non-memory ops.
- `o_lsu_misalign` out 1: accompanies `o_sys_valid`; the access was misaligned and no bus access occurred.
- `o_mem_req` out 1: bus request.
- `o_mem_we` out 1: write.
- `o_mem_addr` out ADDR_W: word-aligned address, with `[1:0]` = 0.
- `o_mem_wdata` out DATA_W: lane-replicated store data.
- `o_mem_wstrb` out 4: byte strobes.
- `i_mem_gnt` in 1: request accepted.
- `i_mem_rvalid` in 1: read data valid.
- `i_mem_rdata` in DATA_W: read word.

## Operation
- FSM states are IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - `o_sys_ready` = 1.
  - On `i_sys_valid`, register ctrl, address and store data.
  - Next state is DONE if there is no memory op or the access is misaligned. Otherwise the next state is REQ.
- **Misalignment**
  - Halfword: `addr[0]` = 1.
  - Word: `addr[1:0]` ≠ 0.
  - Byte accesses are never misaligned.
- **REQ**
  - `o_mem_req` = 1. `o_mem_addr`, `o_mem_we`, `o_mem_wdata` and `o_mem_wstrb` stay stable until grant.
  - On `i_mem_gnt`: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - `o_mem_req` = 0.
  - On `i_mem_rvalid`, capture the extended data into the result register and go to DONE.
  - `i_mem_rvalid` arriving in REQ in the same cycle as the grant is illegal and is ignored.
- **DONE**
  - `o_sys_valid` = 1. `o_lsu_res` and `o_lsu_misalign` are held.
  - On `i_sys_ready`, go to IDLE.
- **Store lanes**
  - SB: wdata = {4{b}}, wstrb = 0001 << `addr[1:0]`.
  - SH: wdata = {2{h}}, wstrb = 0011 << {`addr[1]`, 0}.
  - SW: wstrb = 1111.
- **Load extract**
  - Byte = rdata >> 8·`addr[1:0]`.
  - Half = rdata >> 16·`addr[1]`.
  - LB/LH sign-extend. LBU/LHU zero-extend. Undefined funct3 yields LW behaviour.
- Store and misaligned results: `o_lsu_res` = 0.

## Timing
- **Reset values:** all outputs 0 except `o_sys_ready` = 1. Result, misalign flag and captured ctrl are cleared.
- **Reset mid-operation:** the FSM returns to IDLE immediately. Any outstanding bus response arriving afterwards is ignored, because WAIT is not entered.
- **Latency, accept edge to `o_sys_valid`:**
  - Non-memory or misaligned op: 1 cycle.
  - Store with immediate grant: 2 cycles.
  - Load with immediate grant and `i_mem_rvalid` the next cycle: 3 cycles.
  - Each grant or response stall adds 1 cycle.
- No pipelining: one instruction in flight; `o_sys_ready` = 0 outside IDLE.
- `o_mem_req` depends only on state (registered), never combinationally on `i_mem_gnt`.
- DONE with `i_sys_ready` = 0 holds indefinitely; outputs are unchanged.

## Structure
- The shared core package holds:
  - the funct3 constants (`LSU_LB`…`LSU_SW`);
  - the state enum `lsu_state_e`.
- `DATA_WIDTH`/`ADDR_WIDTH` come from the existing global defines.
- One sub-module, `lsu_align`, is combinational:
  - store path: (funct3, `addr[1:0]`, rs2) → (wdata, wstrb);
  - load path: (funct3, `addr[1:0]`, rdata) → extended result.
- The FSM and registers live in `lsu`.

## Test plan
- **LB sign-extend:** load funct3 000, addr 0x1003, rdata 0x80FF_1234, gnt immediate, rvalid next cycle → `o_mem_addr` 0x1000, `o_lsu_res` 0xFFFF_FF80, valid 3 cycles after accept.
- **LHU:** funct3 101, addr 0x2002, rdata 0xBEEF_0000 → `o_lsu_res` 0x0000_BEEF.
- **SH on upper half:** funct3 001, addr 0x3002, rs2 0x1234_ABCD → wdata 0xABCD_ABCD, wstrb 1100, `o_mem_we` = 1; `o_lsu_res` 0.
- **Stalls:** SW with grant withheld 3 cycles, then writeback `i_sys_ready` low 2 cycles → req and addr stable throughout; valid held; ready returns 1 only after the DONE handshake.
- **Misaligned:** LW at 0x4001 → no `o_mem_req`; valid after 1 cycle with `o_lsu_misalign` = 1, res 0. A non-memory op also completes in 1 cycle with misalign 0.
- **Reset in WAIT:** assert `i_sys_rst` in WAIT, then deliver a late `i_mem_rvalid` → stays IDLE; no `o_sys_valid`; outputs at reset values.
